regfile_dump_reader: RTL



---
 rtl/regfile_dump_reader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// Sweeps a register-file address range through a combinational read port and streams (addr, data) words out.
// Optional XOR checksum of delivered words when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic              Abort,
    input  logic [ADDR_W-1:0] StartAddr,
    input  logic [ADDR_W-1:0] EndAddr,
    output logic [ADDR_W-1:0] RA,
    input  logic [DATA_W-1:0] RD,
    output logic [ADDR_W-1:0] OutAddr,
    output logic [DATA_W-1:0] OutData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              Busy,
    output logic              Halt,
    output logic              Done
`ifdef REGDUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] Checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] cur_q;
    logic [ADDR_W-1:0] end_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [DATA_W-1:0] out_data_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;

    logic              hs_d;
    logic              last_d;
    logic [ADDR_W-1:0] cur_inc_d;

    assign hs_d      = valid_q && OutReady;
    assign last_d    = (cur_q == end_q);
    assign cur_inc_d = cur_q + 1'b1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= S_IDLE;
            cur_q      <= '0;
            end_q      <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        cur_q   <= StartAddr;
                        end_q   <= EndAddr;
                        busy_q  <= 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_READ: begin
                    if (Abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        out_data_q <= RD;
                        out_addr_q <= cur_q;
                        valid_q    <= 1'b1;
                        state_q    <= S_SEND;
                    end
                end
                S_SEND: begin
                    // Abort wins over a simultaneous handshake: the word is not delivered.
                    if (Abort) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (hs_d) begin
                        valid_q <= 1'b0;
                        if (last_d) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            cur_q   <= cur_inc_d;
                            state_q <= S_READ;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // cur_q only moves on entry to READ, so it already holds its last value in IDLE and DONE.
    assign RA       = cur_q;
    assign OutAddr  = out_addr_q;
    assign OutData  = out_data_q;
    assign OutValid = valid_q;
    assign Busy     = busy_q;
    assign Halt     = busy_q;
    assign Done     = done_q;

`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            csum_q <= '0;
        end else if (state_q == S_IDLE && Start) begin
            csum_q <= '0;
        end else if (state_q == S_SEND && hs_d && !Abort) begin
            csum_q <= csum_q ^ out_data_q;
        end
    end

    assign Checksum = csum_q;
`endif

endmodule
